// File: rtl/spdif_pkg.sv
// spdif_pkg: shared constants and types for the S/PDIF (IEC 60958 consumer) encoder.
//   - Preamble cell patterns (line levels for cells 0..7, assuming the line was 0 before).
//   - Frame/block geometry and the slot positions of the V/U/C/P bits.
//   - Subframe selector enum.
package spdif_pkg;

    localparam logic [7:0] PRE_B = 8'b1110_1000;  // subframe A of block frame 0
    localparam logic [7:0] PRE_M = 8'b1110_0010;  // subframe A of every other frame
    localparam logic [7:0] PRE_W = 8'b1110_0100;  // subframe B

    localparam int CELLS_PER_FRAME  = 128;
    localparam int FRAMES_PER_BLOCK = 192;

    localparam logic [4:0] SLOT_AUD0 = 5'd4;
    localparam logic [4:0] SLOT_V    = 5'd28;
    localparam logic [4:0] SLOT_U    = 5'd29;
    localparam logic [4:0] SLOT_C    = 5'd30;
    localparam logic [4:0] SLOT_P    = 5'd31;

    typedef enum logic {
        SF_A = 1'b0,
        SF_B = 1'b1
    } subframe_e;

endpackage

// File: rtl/spdif_bmc_cell.sv
// spdif_bmc_cell: biphase-mark line register, advanced once per cell strobe.
// Ports:
//   i_clk, i_rst    - clock, synchronous active-high reset (line returns to 0)
//   i_cell_en       - one-cycle strobe per biphase cell
//   i_bit           - data bit of the current slot
//   i_second        - 1 on the second cell of a slot, 0 on the first
//   i_pre_en        - current cell is a preamble cell; i_pre_val overrides coding
//   i_pre_first     - current cell is the first preamble cell of a subframe
//   i_pre_val       - preamble line level, as defined for a preceding level of 0
//   o_line          - registered S/PDIF line
module spdif_bmc_cell (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cell_en,
    input  logic i_bit,
    input  logic i_second,
    input  logic i_pre_en,
    input  logic i_pre_first,
    input  logic i_pre_val,
    output logic o_line
);

    logic r_line;
    logic r_pre_inv;
    logic w_inv;
    logic w_next;

    always_comb begin
        // The line level seen just before a preamble decides its polarity for all 8 cells.
        w_inv = i_pre_first ? r_line : r_pre_inv;
        if (i_pre_en) begin
            w_next = i_pre_val ^ w_inv;
        end else if (i_second) begin
            w_next = r_line ^ i_bit;
        end else begin
            w_next = ~r_line;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_line    <= 1'b0;
            r_pre_inv <= 1'b0;
        end else if (i_cell_en) begin
            // Even parity per subframe returns the line to 0 before every preamble,
            // so the inversion path is only a safety net.
            if (i_pre_first) begin
                assert (r_line == 1'b0);
                r_pre_inv <= r_line;
            end
            r_line <= w_next;
        end
    end

    assign o_line = r_line;

endmodule

// File: rtl/spdif_encoder.sv
// spdif_encoder: IEC 60958 consumer S/PDIF transmitter fed by 24-bit stereo pairs.
// Ports:
//   clk, rst          - PLL-domain clock, synchronous active-high reset
//   cell_en           - one-cycle strobe per biphase cell (128 x fs)
//   s_left, s_right   - two's-complement sample pair
//   s_valid, s_ready  - pair handshake; s_ready is high while the holding register is empty
//   spdif_out         - registered biphase-mark line
//   frame_start       - one-clk pulse after the edge that emits cell 0 of a frame
//   underrun          - one-clk pulse when that frame starts with no pair held
module spdif_encoder
    import spdif_pkg::*;
#(
    parameter logic [31:0] CS_BITS = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cell_en,
    input  logic [23:0] s_left,
    input  logic [23:0] s_right,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        spdif_out,
    output logic        frame_start,
    output logic        underrun
);

    logic [6:0]  r_cell_idx;
    logic [7:0]  r_frame_idx;
    logic        r_hold_full;
    logic [23:0] r_hold_l;
    logic [23:0] r_hold_r;
    logic [23:0] r_sh_l;
    logic [23:0] r_sh_r;
    logic        r_v;
    logic        r_par;
    logic        r_frame_start;
    logic        r_underrun;

    subframe_e   w_sf;
    logic [4:0]  w_slot;
    logic [4:0]  w_aud_idx;
    logic        w_second;
    logic        w_load;
    logic        w_accept;
    logic        w_pre_en;
    logic        w_pre_first;
    logic        w_pre_val;
    logic [7:0]  w_pre;
    logic [23:0] w_word;
    logic        w_cs;
    logic        w_bit;
    logic        w_line;

    assign w_sf        = subframe_e'(r_cell_idx[6]);
    assign w_slot      = r_cell_idx[5:1];
    assign w_second    = r_cell_idx[0];
    assign w_load      = cell_en && (r_cell_idx == 7'd0);
    assign w_accept    = s_valid && !r_hold_full;
    assign w_pre_en    = (w_slot < SLOT_AUD0);
    assign w_pre_first = (r_cell_idx[5:0] == 6'd0);
    assign w_aud_idx   = w_pre_en ? 5'd0 : (w_slot - SLOT_AUD0);

    // Slot mux: preamble pattern select and the data bit of the current slot.
    always_comb begin
        if (w_sf == SF_B) begin
            w_pre = PRE_W;
        end else if (r_frame_idx == 8'd0) begin
            w_pre = PRE_B;
        end else begin
            w_pre = PRE_M;
        end
        w_pre_val = w_pre[3'd7 - r_cell_idx[2:0]];

        w_word = (w_sf == SF_A) ? r_sh_l : r_sh_r;
        w_cs   = (r_frame_idx < 8'd32) ? CS_BITS[r_frame_idx[4:0]] : 1'b0;

        case (w_slot)
            SLOT_V:  w_bit = r_v;
            SLOT_U:  w_bit = 1'b0;
            SLOT_C:  w_bit = w_cs;
            SLOT_P:  w_bit = r_par;
            default: w_bit = w_word[w_aud_idx];
        endcase
    end

    // Cell/frame counters and handshake control.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cell_idx    <= 7'd0;
            r_frame_idx   <= 8'd0;
            r_hold_full   <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            r_underrun    <= w_load && !r_hold_full;
            // An accept can only happen while empty, so it never collides with a
            // load that drains a full register.
            if (w_accept) begin
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (cell_en) begin
                r_cell_idx <= r_cell_idx + 7'd1;
                if (r_cell_idx == 7'(CELLS_PER_FRAME - 1)) begin
                    r_frame_idx <= (r_frame_idx == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0
                                                                             : r_frame_idx + 8'd1;
                end
            end
        end
    end

    // Holding register, frame shift registers, V flag and running parity.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold_l <= s_left;
            r_hold_r <= s_right;
        end
        if (w_load) begin
            if (r_hold_full) begin
                r_sh_l <= r_hold_l;
                r_sh_r <= r_hold_r;
                r_v    <= 1'b0;
            end else begin
                r_sh_l <= 24'd0;
                r_sh_r <= 24'd0;
                r_v    <= 1'b1;
            end
        end
        // Parity covers slots 4..30; it restarts during each preamble.
        if (cell_en) begin
            if (w_pre_en) begin
                r_par <= 1'b0;
            end else if (w_second) begin
                r_par <= r_par ^ w_bit;
            end
        end
    end

    spdif_bmc_cell u_bmc (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cell_en   (cell_en),
        .i_bit       (w_bit),
        .i_second    (w_second),
        .i_pre_en    (w_pre_en),
        .i_pre_first (w_pre_first),
        .i_pre_val   (w_pre_val),
        .o_line      (w_line)
    );

    assign s_ready     = !r_hold_full;
    assign spdif_out   = w_line;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_spdif_encoder.sv
`timescale 1ns/1ps
module tb_spdif_encoder;

    localparam logic [31:0] CS  = 32'h0000_0004;
    localparam logic [7:0]  P_B = 8'b1110_1000;
    localparam logic [7:0]  P_M = 8'b1110_0010;
    localparam logic [7:0]  P_W = 8'b1110_0100;

    logic        clk;
    logic        rst;
    logic        cell_en;
    logic [23:0] s_left;
    logic [23:0] s_right;
    logic        s_valid;
    logic        s_ready;
    logic        spdif_out;
    logic        frame_start;
    logic        underrun;

    spdif_encoder #(.CS_BITS(CS)) dut (
        .clk         (clk),
        .rst         (rst),
        .cell_en     (cell_en),
        .s_left      (s_left),
        .s_right     (s_right),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .spdif_out   (spdif_out),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    typedef struct {
        int          fidx;
        logic [23:0] l;
        logic [23:0] r;
        logic        v;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          frames_seen = 0;
    int          cell_per = 4;
    int          div;

    // Transaction-level reference state, updated on every posedge.
    logic        cell_q;
    logic        m_full;
    logic        m_fs;
    logic        m_und;
    logic        m_acc;
    logic [23:0] m_l;
    logic [23:0] m_r;
    int          m_cell;
    int          m_frm;
    exp_t        m_e;

    logic        cells [128];
    int          cap_idx;
    logic        cap_on;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cell strobe generator: one clk high every cell_per clks.
    initial begin
        cell_en = 1'b0;
        div = 0;
        forever begin
            @(negedge clk);
            div = (div + 1 >= cell_per) ? 0 : div + 1;
            cell_en = (div == 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (frames decoded %0d, t=%0t)", nm, got, want, frames_seen, $time);
        end
    endtask

    // Reference model: expected frame contents are queued on each frame-load edge.
    initial begin
        cell_q = 1'b0; m_full = 1'b0; m_fs = 1'b0; m_und = 1'b0; m_acc = 1'b0;
        m_l = '0; m_r = '0; m_cell = 0; m_frm = 0;
        forever begin
            @(posedge clk);
            cell_q = cell_en && !rst;
            m_fs   = 1'b0;
            m_und  = 1'b0;
            if (rst) begin
                m_full = 1'b0;
                m_cell = 0;
                m_frm  = 0;
                exp_q.delete();
            end else begin
                m_acc = s_valid && !m_full;
                if (cell_en && m_cell == 0) begin
                    m_e.fidx = m_frm;
                    m_fs  = 1'b1;
                    m_und = !m_full;
                    if (m_full) begin
                        m_e.l = m_l; m_e.r = m_r; m_e.v = 1'b0;
                        m_full = 1'b0;
                    end else begin
                        m_e.l = '0; m_e.r = '0; m_e.v = 1'b1;
                    end
                    exp_q.push_back(m_e);
                end
                if (m_acc) begin
                    m_l = s_left; m_r = s_right; m_full = 1'b1;
                end
                if (cell_en) begin
                    if (m_cell == 127) begin
                        m_cell = 0;
                        m_frm  = (m_frm == 191) ? 0 : m_frm + 1;
                    end else begin
                        m_cell++;
                    end
                end
            end
        end
    end

    task automatic dec_sf(input int base, output logic [7:0] pre, output logic [23:0] aud,
                          output logic v, output logic u, output logic c, output logic p,
                          output logic bmc_ok);
        logic prev, a, b, bt;
        for (int k = 0; k < 8; k++) pre[7-k] = cells[base+k];
        prev = cells[base+7];
        bmc_ok = 1'b1; aud = '0; v = 1'b0; u = 1'b0; c = 1'b0; p = 1'b0;
        for (int s = 4; s < 32; s++) begin
            a = cells[base+2*s];
            b = cells[base+2*s+1];
            if (a == prev) bmc_ok = 1'b0;
            bt = a ^ b;
            prev = b;
            if (s < 28)       aud[s-4] = bt;
            else if (s == 28) v = bt;
            else if (s == 29) u = bt;
            else if (s == 30) c = bt;
            else              p = bt;
        end
    endtask

    task automatic decode_frame();
        exp_t        e;
        logic [7:0]  pre_a, pre_b;
        logic [23:0] aud_a, aud_b;
        logic        v_a, u_a, c_a, p_a, ok_a;
        logic        v_b, u_b, c_b, p_b, ok_b;
        logic        exp_c;
        frames_seen++;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: frame %0d decoded with no expectation queued", frames_seen);
            return;
        end
        e = exp_q.pop_front();
        dec_sf(0,  pre_a, aud_a, v_a, u_a, c_a, p_a, ok_a);
        dec_sf(64, pre_b, aud_b, v_b, u_b, c_b, p_b, ok_b);
        exp_c = (e.fidx < 32) ? CS[e.fidx] : 1'b0;
        chk("preamble_A", 32'(pre_a), 32'((e.fidx == 0) ? P_B : P_M));
        chk("preamble_B", 32'(pre_b), 32'(P_W));
        chk("left",  32'(aud_a), 32'(e.l));
        chk("right", 32'(aud_b), 32'(e.r));
        chk("V_A",   32'(v_a), 32'(e.v));
        chk("V_B",   32'(v_b), 32'(e.v));
        chk("U_AB",  32'({u_a, u_b}), 32'(0));
        chk("C_A",   32'(c_a), 32'(exp_c));
        chk("C_B",   32'(c_b), 32'(exp_c));
        chk("P_A",   32'(p_a), 32'(^{e.l, e.v, 1'b0, exp_c}));
        chk("P_B",   32'(p_b), 32'(^{e.r, e.v, 1'b0, exp_c}));
        chk("bmc_A", 32'(ok_a), 32'(1));
        chk("bmc_B", 32'(ok_b), 32'(1));
    endtask

    // Monitor: per-cycle control checks and frame capture on the DUT's frame_start.
    initial begin
        cap_on = 1'b0;
        cap_idx = 0;
        forever begin
            @(negedge clk);
            chk("s_ready",     32'(s_ready),     32'(!m_full));
            chk("frame_start", 32'(frame_start), 32'(m_fs));
            chk("underrun",    32'(underrun),    32'(m_und));
            if (rst) begin
                cap_on = 1'b0;
            end else if (cell_q) begin
                if (frame_start) begin
                    cap_on = 1'b1;
                    cap_idx = 0;
                end
                if (cap_on) begin
                    cells[cap_idx] = spdif_out;
                    cap_idx++;
                    if (cap_idx == 128) begin
                        cap_on = 1'b0;
                        decode_frame();
                    end
                end
            end
        end
    end

    task automatic wait_frames(input int n);
        int cyc;
        for (int i = 0; i < n; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!frame_start && cyc < 2000);
            if (!frame_start) begin
                checks++; errors++;
                $display("FAIL frame_timeout: no frame_start within %0d clk", cyc);
            end
        end
    endtask

    task automatic offer(input logic [23:0] l, input logic [23:0] r);
        int   cyc;
        logic rdy;
        @(negedge clk);
        s_left = l; s_right = r; s_valid = 1'b1;
        cyc = 0;
        rdy = s_ready;
        while (!rdy && cyc < 2000) begin
            @(negedge clk);
            rdy = s_ready;
            cyc++;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL accept_timeout: s_ready stayed 0 for %0d clk", cyc);
        end
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_spdif_out",   32'(spdif_out),   32'(0));
        chk("rst_s_ready",     32'(s_ready),     32'(1));
        chk("rst_frame_start", 32'(frame_start), 32'(0));
        chk("rst_underrun",    32'(underrun),    32'(0));
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
        repeat (4) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;

        // Single frame: left bit0, right bit23.
        offer(24'h000001, 24'h800000);
        drop();
        wait_frames(3);

        // Two frames with no data.
        wait_frames(2);

        // Backpressure: s_valid held high across 10 pairs.
        for (int i = 0; i < 10; i++)
            offer(24'h111111 * 24'(i + 1), ~(24'h030507 * 24'(i + 3)));
        drop();
        wait_frames(2);

        // Coincident: second pair is pending while the first is loaded.
        offer(24'h7FFFFF, 24'h000000);
        offer(24'hA5A5A5, 24'h5A5A5A);
        drop();
        wait_frames(3);

        // Reset mid-frame with the holding register full.
        offer(24'h123456, 24'h654321);
        offer(24'hFEDCBA, 24'h0F0F0F);
        drop();
        repeat (150) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_frames(2);

        // Block wrap: faster cells, one pair per frame for 193 frames.
        cell_per = 2;
        for (int i = 0; i < 193; i++)
            offer(24'(i * 40503 + 1), 24'(i * 9973) ^ 24'hC00003);
        drop();
        wait_frames(2);
        chk("pending_expectations", 32'(exp_q.size()), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
